// File: rtl/toy_lsu_pkg.sv
// Shared types and helpers for the toy data-memory load/store adapter.
// Contents: access-size enum, captured-access metadata struct, byte-lane
// enable and store-data replication helpers.
package toy_lsu_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } sz_e;

  // Everything the response stage needs to know about the accepted access
  typedef struct packed {
    logic [1:0] off;
    sz_e        size;
    logic       uns;
    logic       wr;
    logic       err;
  } p1_meta_t;

  // Byte lanes touched by a store of the given size at the given offset
  function automatic logic [LANES-1:0] f_byte_en(input sz_e size, input logic [1:0] off);
    logic [LANES-1:0] be;
    be = '0;
    case (size)
      SZ_B:    be = LANES'(1) << off;
      SZ_H:    be = LANES'(3) << off;
      SZ_W:    be = '1;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across all lanes so any offset lines up
  function automatic logic [WORD_W-1:0] f_wdata_rep(input sz_e size, input logic [WORD_W-1:0] wdata);
    logic [WORD_W-1:0] rep;
    case (size)
      SZ_B:    rep = {4{wdata[7:0]}};
      SZ_H:    rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/toy_dmem_lsu_adapter_if.sv
// Bus bundle between the core/RAM side and the LSU adapter.
// Request/response handshake toward the core plus the 1-cycle-latency RAM port.
// modport master: core + RAM side (drives requests, rsp_rdy, mem_rd_data)
// modport slave : adapter side (drives req_rdy, responses, RAM control)
interface toy_dmem_lsu_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_AW     = 12
);
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_en;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  mem_wr_en;
  logic [3:0]            mem_wr_byte_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    output req_vld, req_addr, req_wr, req_size, req_unsigned, req_wdata, rsp_rdy, mem_rd_data,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err, mem_en, mem_addr, mem_wr_en, mem_wr_byte_en,
           mem_wr_data
  );

  modport slave (
    input  req_vld, req_addr, req_wr, req_size, req_unsigned, req_wdata, rsp_rdy, mem_rd_data,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err, mem_en, mem_addr, mem_wr_en, mem_wr_byte_en,
           mem_wr_data
  );
endinterface

// File: rtl/toy_lsu_load_ext.sv
// Load-data extraction: selects the addressed byte/half lane of the RAM word and
// sign- or zero-extends it to 32 bits.
// Ports: rd_data_i (RAM word), off_i (byte offset), size_i, unsigned_i -> result_o.
module toy_lsu_load_ext
  import toy_lsu_pkg::*;
(
  input  logic [WORD_W-1:0] rd_data_i,
  input  logic [1:0]        off_i,
  input  sz_e               size_i,
  input  logic              unsigned_i,
  output logic [WORD_W-1:0] result_o
);

  logic [15:0] lane;

  // Only the low 16 bits of the shifted word can matter for byte/half loads
  always_comb begin
    lane     = 16'(rd_data_i >> {off_i, 3'b000});
    result_o = rd_data_i;
    case (size_i)
      SZ_B:    result_o = {{24{!unsigned_i && lane[7]}}, lane[7:0]};
      SZ_H:    result_o = {{16{!unsigned_i && lane[15]}}, lane[15:0]};
      default: result_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/toy_dmem_lsu_adapter.sv
// Toy data-memory LSU adapter: converts byte-addressed core loads/stores into
// word-aligned accesses on a 1-cycle-latency RAM and returns extended load data.
// Misaligned, reserved-size and out-of-range accesses are trapped without a RAM access.
// Ports: clk, rst (async, active-high), bus (slave modport: req/rsp handshake + RAM port).
module toy_dmem_lsu_adapter
  import toy_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_AW     = 12
) (
  input logic                   clk,
  input logic                   rst,
  toy_dmem_lsu_adapter_if.slave bus
);

  logic                  p1_vld_q, p1_vld_d;
  p1_meta_t              p1_q, p1_d;
  sz_e                   req_sz;
  logic [1:0]            req_off;
  logic                  req_err;
  logic                  fire;
  logic [DATA_WIDTH-1:0] ext_data;

  // Request decode, trap detection and RAM drive; the RAM sees nothing for trapped requests
  always_comb begin
    req_sz  = sz_e'(bus.req_size);
    req_off = bus.req_addr[1:0];
    req_err = (req_sz == SZ_H && req_off[0])
           || (req_sz == SZ_W && req_off != 2'd0)
           || (req_sz == SZ_RSV)
           || (|bus.req_addr[ADDR_WIDTH-1:MEM_AW+2]);

    // A stalled response blocks new requests so mem_rd_data stays put
    bus.req_rdy        = !rst && (!p1_vld_q || bus.rsp_rdy);
    fire               = bus.req_vld && bus.req_rdy;
    bus.mem_en         = fire && !req_err;
    bus.mem_wr_en      = bus.mem_en && bus.req_wr;
    bus.mem_addr       = bus.req_addr[MEM_AW+1:2];
    bus.mem_wr_byte_en = bus.mem_wr_en ? f_byte_en(req_sz, req_off) : 4'b0000;
    bus.mem_wr_data    = f_wdata_rep(req_sz, bus.req_wdata);
  end

  // Response-stage next state: capture on accept, retire on response handshake
  always_comb begin
    p1_vld_d = p1_vld_q;
    p1_d     = p1_q;
    if (fire) begin
      p1_vld_d  = 1'b1;
      p1_d.off  = req_off;
      p1_d.size = req_sz;
      p1_d.uns  = bus.req_unsigned;
      p1_d.wr   = bus.req_wr;
      p1_d.err  = req_err;
    end else if (p1_vld_q && bus.rsp_rdy) begin
      p1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld_q <= 1'b0;
      p1_q     <= '0;
    end else begin
      p1_vld_q <= p1_vld_d;
      p1_q     <= p1_d;
    end
  end

  toy_lsu_load_ext u_load_ext (
    .rd_data_i  (bus.mem_rd_data),
    .off_i      (p1_q.off),
    .size_i     (p1_q.size),
    .unsigned_i (p1_q.uns),
    .result_o   (ext_data)
  );

  // Read data comes straight from the RAM output; stores and traps return zero
  always_comb begin
    bus.rsp_vld   = p1_vld_q;
    bus.rsp_err   = p1_vld_q && p1_q.err;
    bus.rsp_rdata = (p1_vld_q && !p1_q.wr && !p1_q.err) ? ext_data : '0;
  end

endmodule

// File: tb/tb_toy_dmem_lsu_adapter.sv
// Self-checking bench for toy_dmem_lsu_adapter: byte-level reference memory model,
// per-cycle compare process, and directed vectors with literal expectations.
module tb_toy_dmem_lsu_adapter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toy_dmem_lsu_adapter_if bus ();

  toy_dmem_lsu_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  // RAM with 1-cycle read latency and a backdoor write port
  logic [31:0] ram [4096];
  logic        poke_vld = 1'b0;
  logic [11:0] poke_idx = '0;
  logic [31:0] poke_val = '0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (poke_vld) ram[poke_idx] <= poke_val;
    if (bus.mem_en) begin
      w = ram[bus.mem_addr];
      for (int i = 0; i < 4; i++)
        if (bus.mem_wr_en && bus.mem_wr_byte_en[i]) w[8*i +: 8] = bus.mem_wr_data[8*i +: 8];
      ram[bus.mem_addr]   <= w;
      bus.mem_rd_data     <= ram[bus.mem_addr];
    end
  end

  // Reference model: flat byte memory plus a queue of pending responses
  logic [7:0] ref_mem [16384];
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [1:0] s);
    int n;
    n = 1 << s;
    return (s == 2'd3) || ((a % n) != 0) || (a >= 32'h4000);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int n;
    logic [31:0] v;
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8 * i));
    if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Compare process: every cycle, outputs against the reference model
  always @(negedge clk) begin
    logic        pend, rdy_e, e;
    int          n;
    rsp_t        r;
    logic [31:0] a;
    if (poke_vld)
      for (int i = 0; i < 4; i++) ref_mem[{poke_idx, 2'b00} + 14'(i)] = poke_val[8*i +: 8];
    if (rst) begin
      exp_q.delete();
      chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    end else begin
      pend = exp_q.size() != 0;
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(pend));
      if (pend) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
      end
      rdy_e = !pend || bus.rsp_rdy;
      chk("req_rdy", 32'(bus.req_rdy), 32'(rdy_e));
      if (pend && bus.rsp_rdy) begin
        void'(exp_q.pop_front());
        hs_cnt++;
      end
      if (bus.req_vld && rdy_e) begin
        a = bus.req_addr;
        n = 1 << bus.req_size;
        e = exp_err(a, bus.req_size);
        chk("mem_en", 32'(bus.mem_en), 32'(!e));
        chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(!e && bus.req_wr));
        if (!e) begin
          chk("mem_addr", 32'(bus.mem_addr), a >> 2);
          if (bus.req_wr) begin
            chk("byte_en", 32'(bus.mem_wr_byte_en), ((32'd1 << n) - 32'd1) << (a % 4));
            if (n == 1) chk("wr_data", bus.mem_wr_data, 32'(bus.req_wdata[7:0]) * 32'h01010101);
            else if (n == 2) chk("wr_data", bus.mem_wr_data, 32'(bus.req_wdata[15:0]) * 32'h00010001);
            else chk("wr_data", bus.mem_wr_data, bus.req_wdata);
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = bus.req_wdata[8*i +: 8];
          end else begin
            chk("byte_en_rd", 32'(bus.mem_wr_byte_en), 32'd0);
          end
        end
        r.err   = e;
        r.rdata = (e || bus.req_wr) ? 32'd0 : exp_load(a, bus.req_size, bus.req_unsigned);
        exp_q.push_back(r);
      end else begin
        chk("mem_en_idle", 32'(bus.mem_en), 32'd0);
      end
    end
  end

  // Snapshot of the RAM drive on the accepting cycle
  logic        s_en, s_wen;
  logic [11:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wd;

  task automatic send(input logic [31:0] a, input logic w, input logic [1:0] s,
                      input logic u, input logic [31:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.req_vld      = 1'b1;
    bus.req_addr     = a;
    bus.req_wr       = w;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.req_wdata    = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc    = bus.req_rdy;
      s_en   = bus.mem_en;
      s_wen  = bus.mem_wr_en;
      s_addr = bus.mem_addr;
      s_be   = bus.mem_wr_byte_en;
      s_wd   = bus.mem_wr_data;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_vld = 1'b0;
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout addr %h: no accept within 50 cycles", a);
    end
  endtask

  task automatic poke(input logic [11:0] idx, input logic [31:0] val);
    poke_vld = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clk);
    #1;
    poke_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint      t0;
    int          hs0;
    logic [31:0] rd0;
    rst              = 1'b1;
    bus.req_vld      = 1'b0;
    bus.req_addr     = '0;
    bus.req_wr       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.rsp_rdy      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word store 0x10
    send(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    chk("st_w_en", 32'(s_wen), 32'd1);
    chk("st_w_addr", 32'(s_addr), 32'd4);
    chk("st_w_be", 32'(s_be), 32'hF);
    chk("st_w_wd", s_wd, 32'hDEADBEEF);
    chk("st_w_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    chk("st_w_rsp_rdata", bus.rsp_rdata, 32'd0);

    // Byte load 0x13, signed and unsigned, from word 0x80000000
    poke(12'd4, 32'h8000_0000);
    @(posedge clk);
    #1;
    chk("model_lb_s", exp_load(32'h13, 2'd0, 1'b0), 32'hFFFFFF80);
    chk("model_lb_u", exp_load(32'h13, 2'd0, 1'b1), 32'h00000080);
    send(32'h13, 1'b0, 2'd0, 1'b0, 32'h0);
    chk("lb_s", bus.rsp_rdata, 32'hFFFFFF80);
    send(32'h13, 1'b0, 2'd0, 1'b1, 32'h0);
    chk("lb_u", bus.rsp_rdata, 32'h00000080);

    // Half store 0x6 then read it back signed and unsigned
    send(32'h6, 1'b1, 2'd1, 1'b0, 32'h0000_1234);
    chk("st_h_addr", 32'(s_addr), 32'd1);
    chk("st_h_be", 32'(s_be), 32'hC);
    chk("st_h_wd", s_wd, 32'h12341234);
    send(32'h6, 1'b0, 2'd1, 1'b1, 32'h0);
    chk("lh_u", bus.rsp_rdata, 32'h00001234);
    send(32'h13, 1'b1, 2'd0, 1'b0, 32'h0000_00F1);
    send(32'h12, 1'b0, 2'd1, 1'b0, 32'h0);
    chk("lh_s", bus.rsp_rdata, 32'hFFFFF100);

    // Traps: misaligned half, out of range word, reserved size
    send(32'h1, 1'b0, 2'd1, 1'b0, 32'h0);
    chk("mis_h_en", 32'(s_en), 32'd0);
    chk("mis_h_err", 32'(bus.rsp_err), 32'd1);
    chk("mis_h_rdata", bus.rsp_rdata, 32'd0);
    send(32'h4000, 1'b0, 2'd2, 1'b0, 32'h0);
    chk("oor_en", 32'(s_en), 32'd0);
    chk("oor_err", 32'(bus.rsp_err), 32'd1);
    send(32'h8, 1'b1, 2'd3, 1'b0, 32'h5555_5555);
    chk("rsv_en", 32'(s_en), 32'd0);
    chk("rsv_err", 32'(bus.rsp_err), 32'd1);

    // Back-to-back loads at full rate
    repeat (2) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    t0  = $time;
    send(32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    send(32'h13, 1'b0, 2'd0, 1'b0, 32'h0);
    send(32'h6, 1'b0, 2'd1, 1'b1, 32'h0);
    send(32'h4, 1'b0, 2'd2, 1'b0, 32'h0);
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd4);
    @(negedge clk);
    #1;
    chk("b2b_rsps", 32'(hs_cnt - hs0), 32'd4);
    @(posedge clk);
    #1;

    // Response stall for 3 cycles with a second request waiting
    send(32'h13, 1'b0, 2'd0, 1'b1, 32'h0);
    rd0 = bus.rsp_rdata;
    chk("stall_rd0", rd0, 32'h000000F1);
    bus.rsp_rdy      = 1'b0;
    bus.req_vld      = 1'b1;
    bus.req_addr     = 32'h10;
    bus.req_wr       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("stall_mem_en", 32'(bus.mem_en), 32'd0);
      chk("stall_rsp_vld", 32'(bus.rsp_vld), 32'd1);
      chk("stall_rdata", bus.rsp_rdata, rd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    chk("unstall_req_rdy", 32'(bus.req_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
    chk("unstall_rdata", bus.rsp_rdata, 32'hF1000000);

    // Reset while a response is pending
    @(posedge clk);
    #1;
    send(32'h6, 1'b0, 2'd1, 1'b0, 32'h0);
    chk("pre_rst_vld", 32'(bus.rsp_vld), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(bus.rsp_vld), 32'd0);
    chk("async_rst_rdy", 32'(bus.req_rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    chk("post_rst_rdata", bus.rsp_rdata, 32'hF1000000);
    @(posedge clk);
    #1;
    chk("post_rst_no_stale", 32'(bus.rsp_vld), 32'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
